// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit: op encoding, FSM states, access size.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    SB  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    SH  = 3'b110,
    SW  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_load(op_e op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_unsigned(op_e op);
    return (op == LBU) || (op == LHU);
  endfunction

  // Anything not explicitly byte or half is handled as a full word.
  function automatic size_e size_of(op_e op);
    case (op)
      LB, LBU, SB: return SZ_B;
      LH, LHU, SH: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(op_e op, logic [1:0] lo);
    case (size_of(op))
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response handshake plus the word-wide dmem port of the load/store unit.
interface lsu_ctrl_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  lsu_pkg::op_e      req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_a;
  logic [31:0]       dm_wd;
  logic [31:0]       dm_rd;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, dm_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_a, dm_wd
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, dm_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_a, dm_wd
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte/half lane extract with sign/zero extension, and sub-word store merge.
// Lane numbering follows BIG_ENDIAN; zero latency, no flow control.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  op_e         op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [1:0]  b_lane;
  logic        h_lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // Big-endian mirrors the lane index: byte 0 lives in bits 31:24.
    b_lane  = BIG_ENDIAN ? ~addr_lo : addr_lo;
    h_lane  = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    byte_v  = rd_word[8*b_lane +: 8];
    half_v  = rd_word[16*h_lane +: 16];
    ld_data = rd_word;
    st_word = st_data;
    case (size_of(op))
      SZ_B: begin
        ld_data = is_unsigned(op) ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        st_word = rd_word;
        st_word[8*b_lane +: 8] = st_data[7:0];
      end
      SZ_H: begin
        ld_data = is_unsigned(op) ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        st_word = rd_word;
        st_word[16*h_lane +: 16] = st_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// One-at-a-time load/store initiator with read-modify-write sub-word stores; LSU_ERR_EN makes misaligned ops fail.
// Accept-to-resp: misaligned 1, loads/SW 2, SB/SH 3; resp held until resp_ready, no accept while busy.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);

`ifdef LSU_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              misal;
  logic [ADDR_W-1:0] addr_fix;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;

  lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .op      (req_q.op),
    .addr_lo (addr_q[1:0]),
    .rd_word (bus.dm_rd),
    .st_data (req_q.wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // Without error reporting, misaligned low bits are simply dropped.
  always_comb begin
    misal    = misaligned(bus.req_op, bus.req_addr[1:0]);
    addr_fix = bus.req_addr;
    case (size_of(bus.req_op))
      SZ_H:    addr_fix[0]   = 1'b0;
      SZ_W:    addr_fix[1:0] = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d   = '{op: bus.req_op, wdata: bus.req_wdata};
          addr_d  = addr_fix;
          wd_d    = bus.req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = (bus.req_op == SW) ? ST_WRITE : ST_READ;
          if (ErrEn && misal) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_READ: begin
        if (is_store(req_q.op)) begin
          wd_d    = st_word;
          state_d = ST_WRITE;
        end else begin
          rdata_d = ld_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.dm_we      = (state_q == ST_WRITE);
    bus.dm_a       = '0;
    if (state_q == ST_READ || state_q == ST_WRITE) bus.dm_a = {addr_q[ADDR_W-1:2], 2'b00};
    bus.dm_wd      = (state_q == ST_WRITE) ? wd_q : '0;
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a byte-array reference memory; honours LSU_ERR_EN.
module tb_lsu_ctrl;
  import lsu_pkg::*;

`ifdef LSU_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_ctrl #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] mem [0:63] = '{default: '0};
  logic [7:0]  ref_b [0:255] = '{default: '0};

  assign bus.dm_rd = mem[bus.dm_a[7:2]];
  always @(posedge clk) if (bus.dm_we) mem[bus.dm_a[7:2]] <= bus.dm_wd;

  int n_tests = 0;
  int n_fail = 0;
  int we_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  always @(negedge clk) begin
    if (bus.dm_we) begin
      we_cnt++;
      last_wa = bus.dm_a;
      last_wd = bus.dm_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(int wa);
    return {ref_b[wa+3], ref_b[wa+2], ref_b[wa+1], ref_b[wa]};
  endfunction

  // Little-endian byte memory: loads read bytes, stores overwrite bytes.
  task automatic ref_apply(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] e_rd, output logic e_err, output int e_lat,
                           output int e_we, output int e_wa);
    int sz, a, ea;
    a  = int'(addr[7:0]);
    sz = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
    ea = a - (a % sz);
    e_wa  = ea - (ea % 4);
    e_rd  = '0;
    e_err = 1'b0;
    e_we  = (op == SB || op == SH || op == SW) ? 1 : 0;
    e_lat = (op == SB || op == SH) ? 3 : 2;
    if (ERR_EN && (a % sz) != 0) begin
      e_err = 1'b1;
      e_lat = 1;
      e_we  = 0;
      e_wa  = 0;
      return;
    end
    case (op)
      LB:  e_rd = {{24{ref_b[ea][7]}}, ref_b[ea]};
      LBU: e_rd = {24'h0, ref_b[ea]};
      LH:  e_rd = {{16{ref_b[ea+1][7]}}, ref_b[ea+1], ref_b[ea]};
      LHU: e_rd = {16'h0, ref_b[ea+1], ref_b[ea]};
      SB:  ref_b[ea] = wdata[7:0];
      SH:  begin ref_b[ea] = wdata[7:0]; ref_b[ea+1] = wdata[15:8]; end
      SW:  begin
        ref_b[ea]   = wdata[7:0];
        ref_b[ea+1] = wdata[15:8];
        ref_b[ea+2] = wdata[23:16];
        ref_b[ea+3] = wdata[31:24];
      end
      default: e_rd = ref_word(e_wa);
    endcase
  endtask

  task automatic xact(input string tag, input op_e op, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold, input bit poke,
                      output logic [31:0] rd_got);
    logic [31:0] e_rd, first_a;
    logic        e_err, err_got;
    int          e_lat, e_we, e_wa, lat, we0;
    bit          done;
    ref_apply(op, addr, wdata, e_rd, e_err, e_lat, e_we, e_wa);
    @(negedge clk);
    chk({tag, ".req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    we0 = we_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0;
    first_a = bus.dm_a;
    lat  = 1;
    done = 1'b0;
    while (!done && lat < 20) begin
      if (bus.resp_valid) done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, ".latency"}, lat, e_lat);
    rd_got  = bus.resp_rdata;
    err_got = bus.resp_err;
    chk({tag, ".rdata"}, rd_got, e_rd);
    chk({tag, ".err"}, {31'h0, err_got}, {31'h0, e_err});
    chk({tag, ".dm_a"}, first_a, e_wa);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_op    = SW;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      chk({tag, ".hold_vld"}, {31'h0, bus.resp_valid}, 32'h1);
      chk({tag, ".hold_rdata"}, bus.resp_rdata, rd_got);
      chk({tag, ".hold_err"}, {31'h0, bus.resp_err}, {31'h0, err_got});
      chk({tag, ".hold_rdy"}, {31'h0, bus.req_ready}, 32'h0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, ".vld_drop"}, {31'h0, bus.resp_valid}, 32'h0);
    chk({tag, ".we_pulses"}, we_cnt - we0, e_we);
    if (e_we != 0) begin
      chk({tag, ".wr_addr"}, last_wa, e_wa);
      chk({tag, ".wr_data"}, last_wd, ref_word(e_wa));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rd;
    int bad, we_snap;
    bus.req_valid  = 1'b0;
    bus.req_op     = LB;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    #2;
    chk("rst.req_ready",  {31'h0, bus.req_ready},  32'h1);
    chk("rst.resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst.resp_err",   {31'h0, bus.resp_err},   32'h0);
    chk("rst.dm_we",      {31'h0, bus.dm_we},      32'h0);
    chk("rst.dm_a",       bus.dm_a,  32'h0);
    chk("rst.dm_wd",      bus.dm_wd, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    xact("t1.sw", SW, 32'h4, 32'h1234_5678, 0, 1'b0, rd);
    chk("t1.wd_const", last_wd, 32'h1234_5678);
    xact("t1.lw", LW, 32'h4, 32'h0, 0, 1'b0, rd);
    chk("t1.lw_const", rd, 32'h1234_5678);

    xact("t2.sb", SB, 32'h5, 32'hFFFF_FFAA, 0, 1'b0, rd);
    chk("t2.wd_const", last_wd, 32'h1234_AA78);
    xact("t2.lbu", LBU, 32'h5, 32'h0, 0, 1'b0, rd);
    chk("t2.lbu_const", rd, 32'h0000_00AA);
    xact("t2.lb", LB, 32'h5, 32'h0, 1, 1'b0, rd);
    chk("t2.lb_const", rd, 32'hFFFF_FFAA);

    xact("t3.sh", SH, 32'h6, 32'h0000_BEEF, 0, 1'b0, rd);
    chk("t3.wd_const", last_wd, 32'hBEEF_AA78);
    xact("t3.lh", LH, 32'h6, 32'h0, 0, 1'b0, rd);
    chk("t3.lh_const", rd, 32'hFFFF_BEEF);
    xact("t3.lhu", LHU, 32'h6, 32'h0, 0, 1'b0, rd);
    chk("t3.lhu_const", rd, 32'h0000_BEEF);
    xact("t3.lw", LW, 32'h4, 32'h0, 0, 1'b0, rd);
    chk("t3.lw_const", rd, 32'hBEEF_AA78);

    xact("t4.lw_mis", LW, 32'h9, 32'h0, 0, 1'b0, rd);
    xact("t4.sh_mis", SH, 32'h7, 32'h0000_1234, 0, 1'b0, rd);

    xact("t5.hold", LW, 32'h4, 32'h0, 3, 1'b1, rd);

    // Abort an SB while it is reading: nothing may be written.
    @(negedge clk);
    we_snap = we_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = SB;
    bus.req_addr  = 32'h5;
    bus.req_wdata = 32'h0000_0055;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("t6.in_read_a", bus.dm_a, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.req_ready",  {31'h0, bus.req_ready},  32'h1);
    chk("t6.resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("t6.resp_rdata", bus.resp_rdata, 32'h0);
    chk("t6.resp_err",   {31'h0, bus.resp_err},   32'h0);
    chk("t6.dm_we",      {31'h0, bus.dm_we},      32'h0);
    chk("t6.dm_a",       bus.dm_a,  32'h0);
    chk("t6.dm_wd",      bus.dm_wd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6.no_write", we_cnt - we_snap, 0);
    chk("t6.mem_word", mem[1], ref_word(4));
    chk("t6.ready_after", {31'h0, bus.req_ready}, 32'h1);

    for (int n = 0; n < 200; n++) begin
      xact("rnd", op_e'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom,
           int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rd);
    end

    bad = 0;
    for (int w = 0; w < 64; w++) if (mem[w] !== ref_word(4 * w)) bad++;
    chk("final.mem_words_bad", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
